// File: rtl/trade_risk_engine_pkg.sv
// Shared declarations for the trade risk engine.
//   NUM_CLIENTS / AMT_W / MAX_W / ID_W / EXP_W : table sizes and datapath widths
//   cache_req_type : read/write index bundle for the cancelled-order register file
//   sat_add        : AMT_W-bit add that saturates at all-ones
package cache_def;

  localparam int unsigned NUM_CLIENTS = 32;
  localparam int unsigned AMT_W       = 16;
  localparam int unsigned MAX_W       = 32;
  localparam int unsigned ID_W        = 5;
  localparam int unsigned EXP_W       = AMT_W + 2;

  typedef struct packed {
    logic [ID_W-1:0] rdindex;
    logic [ID_W-1:0] wrindex;
    logic            we;
  } cache_req_type;

  function automatic logic [AMT_W-1:0] sat_add(input logic [AMT_W-1:0] a,
                                               input logic [AMT_W-1:0] b);
    logic [AMT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[AMT_W] ? '1 : sum[AMT_W-1:0];
  endfunction

endpackage

// File: rtl/trade_risk_engine_cancel_ram.sv
// Cancelled-order register file, NUM_CLIENTS x AMT_W.
//   clk, HRESETn : clock, synchronous active-low clear of every entry
//   data_req     : rdindex (async read), wrindex + we (write)
//   data_write   : amount accumulated (saturating) into entry wrindex on write
//   data_read    : current contents of entry rdindex
module cancel_ram
  import cache_def::*;
(
  input  logic             clk,
  input  logic             HRESETn,
  input  cache_req_type    data_req,
  input  logic [AMT_W-1:0] data_write,
  output logic [AMT_W-1:0] data_read
);

  logic [AMT_W-1:0] mem [NUM_CLIENTS];

  // Write is read-modify-write so the exchange side needs no second read port.
  always_ff @(posedge clk) begin
    if (!HRESETn) begin
      for (int unsigned i = 0; i < NUM_CLIENTS; i++) mem[i] <= '0;
    end else if (data_req.we) begin
      mem[data_req.wrindex] <= sat_add(mem[data_req.wrindex], data_write);
    end
  end

  assign data_read = mem[data_req.rdindex];

endmodule

// File: rtl/trade_risk_engine.sv
// Per-client pre-trade risk engine.
//   clk, HRESETn        : clock, synchronous active-low reset
//   cpu_client_id       : CPU-side client; also selects the readback outputs
//   cpu_amount          : order amount, or new limit when cpu_new_max
//   cpu_go / cpu_new_max: order strobe / limit-load strobe (limit load wins)
//   exchange_*          : cancellation report (client, amount, strobe)
//   cancelled_orders, accumulated_orders, max_to_trade : registered post-update
//                         table entries of cpu_client_id
//   order_accepted / order_rejected : registered one-cycle result pulses
// Optional macro RISK_ASSERT_EN compiles in an exposure-vs-limit assertion.
module trade_risk_engine
  import cache_def::*;
(
  input  logic             clk,
  input  logic             HRESETn,
  input  logic [ID_W-1:0]  cpu_client_id,
  input  logic [AMT_W-1:0] cpu_amount,
  input  logic             cpu_go,
  input  logic             cpu_new_max,
  input  logic [ID_W-1:0]  exchange_client_id,
  input  logic [AMT_W-1:0] exchange_amount,
  input  logic             exchange_go,
  output logic [AMT_W-1:0] cancelled_orders,
  output logic [AMT_W-1:0] accumulated_orders,
  output logic [MAX_W-1:0] max_to_trade,
  output logic             order_accepted,
  output logic             order_rejected
);

  logic [MAX_W-1:0] max_tbl   [NUM_CLIENTS];
  logic [AMT_W-1:0] accum_tbl [NUM_CLIENTS];

  cache_req_type    cancel_req;
  logic [AMT_W-1:0] cancel_rd;

  logic [MAX_W-1:0] max_rd, max_nxt;
  logic [AMT_W-1:0] acc_rd, acc_nxt, cancel_nxt;
  logic [EXP_W-1:0] exposure;
  logic             order_go, safe, accept_nxt, reject_nxt;

  assign cancel_req.rdindex = cpu_client_id;
  assign cancel_req.wrindex = exchange_client_id;
  assign cancel_req.we      = exchange_go;

  cancel_ram u_cancel_ram (
    .clk        (clk),
    .HRESETn    (HRESETn),
    .data_req   (cancel_req),
    .data_write (exchange_amount),
    .data_read  (cancel_rd)
  );

  // Risk check on pre-edge entries and next values for the addressed client.
  always_comb begin
    max_rd     = max_tbl[cpu_client_id];
    acc_rd     = accum_tbl[cpu_client_id];
    order_go   = cpu_go && !cpu_new_max;
    exposure   = EXP_W'(acc_rd) + EXP_W'(cpu_amount) - EXP_W'(cancel_rd);
    // Negative exposure clamps to 0, which is below any nonzero limit.
    safe       = exposure[EXP_W-1] ? (max_rd != '0)
                                   : (MAX_W'(exposure[EXP_W-2:0]) < max_rd);
    accept_nxt = order_go && safe;
    reject_nxt = order_go && !safe;
    max_nxt    = cpu_new_max ? MAX_W'(cpu_amount) : max_rd;
    acc_nxt    = accept_nxt ? sat_add(acc_rd, cpu_amount) : acc_rd;
    // Readback reflects a same-edge cancellation on the selected client.
    cancel_nxt = (exchange_go && (exchange_client_id == cpu_client_id))
                 ? sat_add(cancel_rd, exchange_amount) : cancel_rd;
  end

  always_ff @(posedge clk) begin
    if (!HRESETn) begin
      for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
        max_tbl[i]   <= '0;
        accum_tbl[i] <= '0;
      end
      cancelled_orders   <= '0;
      accumulated_orders <= '0;
      max_to_trade       <= '0;
      order_accepted     <= 1'b0;
      order_rejected     <= 1'b0;
    end else begin
      max_tbl[cpu_client_id]   <= max_nxt;
      accum_tbl[cpu_client_id] <= acc_nxt;
      cancelled_orders         <= cancel_nxt;
      accumulated_orders       <= acc_nxt;
      max_to_trade             <= max_nxt;
      order_accepted           <= accept_nxt;
      order_rejected           <= reject_nxt;
    end
  end

`ifdef RISK_ASSERT_EN
  logic [ID_W-1:0]  rd_id_q;
  logic [MAX_W-1:0] net_c;

  always_ff @(posedge clk) begin
    if (!HRESETn) rd_id_q <= '0;
    else          rd_id_q <= cpu_client_id;
  end

  assign net_c = (accumulated_orders > cancelled_orders)
                 ? MAX_W'(accumulated_orders - cancelled_orders) : '0;

  a_exposure_below_limit: assert property (
    @(posedge clk) disable iff (!HRESETn)
      (max_to_trade == '0) || (max_to_trade > net_c))
    else $error("risk exposure: client %0d max %0d accumulated %0d cancelled %0d",
                rd_id_q, max_to_trade, accumulated_orders, cancelled_orders);
`endif

endmodule

// File: tb/tb_trade_risk_engine.sv
module tb_trade_risk_engine;

  logic        clk;
  logic        HRESETn;
  logic [4:0]  cpu_client_id;
  logic [15:0] cpu_amount;
  logic        cpu_go;
  logic        cpu_new_max;
  logic [4:0]  exchange_client_id;
  logic [15:0] exchange_amount;
  logic        exchange_go;
  logic [15:0] cancelled_orders;
  logic [15:0] accumulated_orders;
  logic [31:0] max_to_trade;
  logic        order_accepted;
  logic        order_rejected;

  trade_risk_engine dut (
    .clk                (clk),
    .HRESETn            (HRESETn),
    .cpu_client_id      (cpu_client_id),
    .cpu_amount         (cpu_amount),
    .cpu_go             (cpu_go),
    .cpu_new_max        (cpu_new_max),
    .exchange_client_id (exchange_client_id),
    .exchange_amount    (exchange_amount),
    .exchange_go        (exchange_go),
    .cancelled_orders   (cancelled_orders),
    .accumulated_orders (accumulated_orders),
    .max_to_trade       (max_to_trade),
    .order_accepted     (order_accepted),
    .order_rejected     (order_rejected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference tables as plain integers.
  int m_max [32];
  int m_acc [32];
  int m_can [32];

  int exp_max, exp_acc, exp_can, exp_ok, exp_rej;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Compare DUT against the model every cycle once the model is primed.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("max_to_trade",       max_to_trade,       exp_max);
      check("accumulated_orders", accumulated_orders, exp_acc);
      check("cancelled_orders",   cancelled_orders,   exp_can);
      check("order_accepted",     order_accepted,     exp_ok);
      check("order_rejected",     order_rejected,     exp_rej);
    end
  end

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  // Drive one cycle of stimulus and advance the model by one edge.
  task automatic step(input bit rst_n, input int id, input int amt, input bit go,
                      input bit nm, input int xid, input int xamt, input bit xgo);
    int e;
    int pre_can_x;
    @(negedge clk);
    #1;
    HRESETn            = rst_n;
    cpu_client_id      = 5'(id);
    cpu_amount         = 16'(amt);
    cpu_go             = go;
    cpu_new_max        = nm;
    exchange_client_id = 5'(xid);
    exchange_amount    = 16'(xamt);
    exchange_go        = xgo;
    exp_ok  = 0;
    exp_rej = 0;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        m_max[i] = 0; m_acc[i] = 0; m_can[i] = 0;
      end
      exp_max = 0; exp_acc = 0; exp_can = 0;
    end else begin
      pre_can_x = m_can[xid];
      if (nm) begin
        m_max[id] = amt;
      end else if (go) begin
        e = m_acc[id] + amt - m_can[id];
        if (e < 0) e = 0;
        if (e < m_max[id]) begin
          m_acc[id] = sat16(m_acc[id] + amt);
          exp_ok = 1;
        end else begin
          exp_rej = 1;
        end
      end
      if (xgo) m_can[xid] = sat16(pre_can_x + xamt);
      exp_max = m_max[id];
      exp_acc = m_acc[id];
      exp_can = m_can[id];
    end
    cmp_en = 1'b1;
  endtask

  task automatic idle(input int id);
    step(1'b1, id, 0, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  int rid, ramt, rxid, rxamt;
  bit rgo, rnm, rxgo;

  initial begin
    HRESETn = 1'b0; cpu_client_id = '0; cpu_amount = '0; cpu_go = 1'b0;
    cpu_new_max = 1'b0; exchange_client_id = '0; exchange_amount = '0;
    exchange_go = 1'b0;

    step(1'b0, 3, 0, 1'b0, 1'b0, 0, 0, 1'b0);
    step(1'b0, 3, 0, 1'b0, 1'b0, 0, 0, 1'b0);
    idle(3);
    check("model_reset_max", exp_max, 0);

    // Limit gating on client 3.
    step(1'b1, 3, 100, 1'b0, 1'b1, 0, 0, 1'b0);
    check("model_limit100", exp_max, 100);
    step(1'b1, 3, 40, 1'b1, 1'b0, 0, 0, 1'b0);
    check("model_acc40_ok", exp_ok, 1);
    check("model_acc40", exp_acc, 40);
    step(1'b1, 3, 70, 1'b1, 1'b0, 0, 0, 1'b0);
    check("model_rej70", exp_rej, 1);
    check("model_acc_stays40", exp_acc, 40);

    // Cancellation frees headroom.
    step(1'b1, 3, 0, 1'b0, 1'b0, 3, 30, 1'b1);
    check("model_can30", exp_can, 30);
    step(1'b1, 3, 70, 1'b1, 1'b0, 0, 0, 1'b0);
    check("model_acc110_ok", exp_ok, 1);
    check("model_acc110", exp_acc, 110);

    // Same-cycle collisions on client 5.
    step(1'b1, 5, 50, 1'b0, 1'b1, 0, 0, 1'b0);
    step(1'b1, 5, 45, 1'b1, 1'b0, 0, 0, 1'b0);
    step(1'b1, 5, 10, 1'b1, 1'b0, 5, 20, 1'b1);
    check("model_collide_rej", exp_rej, 1);
    check("model_collide_can20", exp_can, 20);
    step(1'b1, 5, 200, 1'b1, 1'b1, 0, 0, 1'b0);
    check("model_nm_prio_max", exp_max, 200);
    check("model_nm_prio_nopulse", exp_ok + exp_rej, 0);
    check("model_nm_prio_acc", exp_acc, 45);

    // Cancel saturation on client 7 (readback on a different client).
    step(1'b1, 3, 0, 1'b0, 1'b0, 7, 16'hFFF0, 1'b1);
    step(1'b1, 7, 0, 1'b0, 1'b0, 7, 16'h0020, 1'b1);
    check("model_can_sat", exp_can, 65535);

    // Limit 0 rejects everything.
    step(1'b1, 9, 1, 1'b1, 1'b0, 0, 0, 1'b0);
    check("model_lim0_rej", exp_rej, 1);
    step(1'b1, 3, 0, 1'b0, 1'b1, 0, 0, 1'b0);
    step(1'b1, 3, 1, 1'b1, 1'b0, 0, 0, 1'b0);
    check("model_lim0_rej3", exp_rej, 1);

    // Accumulator saturation on client 11.
    step(1'b1, 11, 16'hFFFF, 1'b0, 1'b1, 11, 16'hFFFF, 1'b1);
    step(1'b1, 11, 16'h8000, 1'b1, 1'b0, 0, 0, 1'b0);
    step(1'b1, 11, 16'h9000, 1'b1, 1'b0, 0, 0, 1'b0);
    check("model_acc_sat", exp_acc, 65535);

    // Readback follows client id with no strobe.
    idle(5);
    idle(3);

    // Mid-operation reset discards same-cycle strobes.
    step(1'b0, 3, 5, 1'b1, 1'b0, 3, 5, 1'b1);
    idle(3);

    // Randomized traffic over a few clients to provoke collisions.
    for (int n = 0; n < 2000; n++) begin
      rid   = int'($urandom_range(0, 7));
      rxid  = int'($urandom_range(0, 7));
      rgo   = ($urandom_range(0, 1) == 0);
      rnm   = ($urandom_range(0, 9) == 0);
      rxgo  = ($urandom_range(0, 4) < 2);
      ramt  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 65535))
                                          : int'($urandom_range(0, 300));
      rxamt = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 65535))
                                           : int'($urandom_range(0, 100));
      // New limits never drop below the current exposure (or are 0).
      if (rnm) begin
        if ($urandom_range(0, 3) == 0 || m_acc[rid] >= 65535) ramt = 0;
        else ramt = int'($urandom_range(32'(m_acc[rid] + 1), 65535));
      end
      step(($urandom_range(0, 499) != 0), rid, ramt, rgo, rnm, rxid, rxamt, rxgo);
    end

    idle(0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
